// File: rtl/regfile_dump_reader.sv
// Streams (index, data) pairs from one register-file read port over valid/ready.
// One output slot register; a word is read in the cycle the slot frees up.
module regfile_dump_reader #(
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 32,
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] Read_Reg,
  input  logic [DATA_W-1:0] Read_Data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_index,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done
);

  generate
    if (LAST_REG < FIRST_REG) begin : g_bad_range
      $error("regfile_dump_reader: LAST_REG must be >= FIRST_REG");
    end
  endgenerate

  localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(FIRST_REG);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(LAST_REG);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] idx;
  logic              slot_free;
  logic              idx_init, idx_inc, load, clr_valid, done_nx;

  assign slot_free = !out_valid || out_ready;
  assign busy      = (state != IDLE);
  assign Read_Reg  = (state == READ) ? idx : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    idx_init  = 1'b0;
    idx_inc   = 1'b0;
    load      = 1'b0;
    clr_valid = 1'b0;
    done_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          idx_init = 1'b1;
          state_nx = READ;
        end
      end
      READ: begin
        if (abort) begin
          clr_valid = 1'b1;
          state_nx  = IDLE;
        end else if (slot_free) begin
          load = 1'b1;
          // Leave via DRAIN at the last index so idx never wraps.
          if (idx == LAST_IDX) state_nx = DRAIN;
          else                 idx_inc  = 1'b1;
        end
      end
      DRAIN: begin
        if (abort) begin
          clr_valid = 1'b1;
          state_nx  = IDLE;
        end else if (slot_free) begin
          clr_valid = 1'b1;
          done_nx   = 1'b1;
          state_nx  = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      out_valid <= 1'b0;
      out_index <= '0;
      out_data  <= '0;
      done      <= 1'b0;
    end else begin
      done <= done_nx;
      if (idx_init)     idx <= FIRST_IDX;
      else if (idx_inc) idx <= idx + ADDR_W'(1);
      if (load) begin
        out_data  <= Read_Data;
        out_index <= idx;
      end
      if (clr_valid)                   out_valid <= 1'b0;
      else if (load)                   out_valid <= 1'b1;
      else if (out_valid && out_ready) out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench: full dumps, back-pressure, ignored start, abort, live writes,
// single-register range and asynchronous reset.
module tb_regfile_dump_reader;

  logic        clk = 1'b0;
  logic        rst_n, start, abort, out_ready;
  logic [4:0]  Read_Reg, out_index;
  logic [31:0] Read_Data, out_data;
  logic        out_valid, busy, done;

  logic        start1;
  logic [4:0]  rr1, oi1;
  logic [31:0] rd1, od1;
  logic        ov1, busy1, done1;

  logic [31:0] rf [32];
  logic [31:0] r20_exp;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  assign Read_Data = rf[Read_Reg];
  assign rd1       = rf[rr1];

  regfile_dump_reader #(.ADDR_W(5), .DATA_W(32), .FIRST_REG(0), .LAST_REG(31)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .Read_Reg(Read_Reg), .Read_Data(Read_Data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_index(out_index), .out_data(out_data),
    .busy(busy), .done(done)
  );

  regfile_dump_reader #(.ADDR_W(5), .DATA_W(32), .FIRST_REG(17), .LAST_REG(17)) u_one (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(1'b0),
    .Read_Reg(rr1), .Read_Data(rd1),
    .out_valid(ov1), .out_ready(1'b1),
    .out_index(oi1), .out_data(od1),
    .busy(busy1), .done(done1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_val(input int i);
    case (i)
      16:      return 32'd4;
      17:      return 32'd7;
      20:      return r20_exp;
      default: return 32'd0;
    endcase
  endfunction

  // Register file write: reg 0 is hardwired to zero.
  task automatic rf_wr(input int a, input logic [31:0] d);
    if (a != 0) rf[a] = d;
  endtask

  task automatic pulse_start;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("first_not_yet_valid", 32'(out_valid), 32'd0);
    chk("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic expect_words(input int from, input int to);
    for (int i = from; i <= to; i++) begin
      @(negedge clk);
      chk($sformatf("valid_%0d", i), 32'(out_valid), 32'd1);
      chk($sformatf("index_%0d", i), 32'(out_index), 32'(i));
      chk($sformatf("data_%0d", i), out_data, exp_val(i));
    end
  endtask

  task automatic expect_done;
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_end", 32'(busy), 32'd0);
    chk("valid_end", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("done_single_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    rf[16] = 32'd4;
    rf[17] = 32'd7;
    r20_exp = 32'd0;
    rst_n = 1'b0; start = 1'b0; start1 = 1'b0; abort = 1'b0; out_ready = 1'b1;
    #12;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_read_reg", 32'(Read_Reg), 32'd0);
    chk("rst_index", 32'(out_index), 32'd0);
    chk("rst_data", out_data, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // start while idle in a fresh state, full dump with ready high
    pulse_start;
    expect_words(0, 31);
    expect_done;

    // back-pressure while word 16 sits in the slot
    pulse_start;
    expect_words(0, 16);
    out_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_index", 32'(out_index), 32'd16);
      chk("stall_data", out_data, 32'd4);
      chk("stall_read_reg", 32'(Read_Reg), 32'd17);
    end
    out_ready = 1'b1;
    expect_words(17, 31);
    expect_done;

    // start while busy is ignored; abort ends the dump without done
    pulse_start;
    expect_words(0, 5);
    start = 1'b1;
    expect_words(6, 6);
    start = 1'b0;
    expect_words(7, 9);
    abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_done", 32'(done), 32'd0);
      chk("abort_stays_idle", 32'(busy), 32'd0);
    end

    // live write to reg 20 lands before it is read; reg 0 write is dropped
    rf_wr(0, 32'h1234_5678);
    pulse_start;
    expect_words(0, 17);
    rf_wr(20, 32'hDEAD_BEEF);
    r20_exp = 32'hDEAD_BEEF;
    expect_words(18, 31);
    expect_done;

    // single-register range
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
    chk("one_busy", 32'(busy1), 32'd1);
    @(negedge clk);
    chk("one_valid", 32'(ov1), 32'd1);
    chk("one_index", 32'(oi1), 32'd17);
    chk("one_data", od1, 32'd7);
    @(negedge clk);
    chk("one_done", 32'(done1), 32'd1);
    chk("one_valid_clear", 32'(ov1), 32'd0);
    @(negedge clk);
    chk("one_done_single", 32'(done1), 32'd0);
    chk("one_idle", 32'(busy1), 32'd0);

    // asynchronous reset mid-dump, sampled between clock edges
    pulse_start;
    expect_words(0, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_read_reg", 32'(Read_Reg), 32'd0);
    chk("arst_index", 32'(out_index), 32'd0);
    #1 rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("arst_no_done", 32'(done), 32'd0);
      chk("arst_idle", 32'(busy), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
